// File: rtl/sseg_iobus_ctrl.sv
// Seven-segment display controller on the OTTER IOBUS.
// Holds a 16-bit hex value and control bits, and scans four digits.
module sseg_iobus_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h1100C010,
  parameter int          REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        RST,
  input  logic [31:0] iobus_addr,
  input  logic [31:0] iobus_out,
  input  logic        iobus_wr,
  output logic [31:0] iobus_rd_data,
  output logic        iobus_hit,
  output logic [7:0]  segs,
  output logic [3:0]  an
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(REFRESH_DIV - 1);

  logic [15:0]   data_q;
  logic [9:0]    ctrl_q;
  logic [CW-1:0] ref_cnt;
  logic [1:0]    idx;
  logic [7:0]    frame;

  logic sel_data;
  logic sel_ctrl;
  logic sel_stat;

  logic [3:0] blank;
  logic [3:0] dp;
  logic [3:0] nib;
  logic       lead_zero;
  logic       dark;
  logic [6:0] glyph;
  logic [7:0] segs_next;
  logic [3:0] an_next;

  logic unused_hi;
  assign unused_hi = ^iobus_out[31:16];

  assign sel_data = (iobus_addr == BASE_ADDR);
  assign sel_ctrl = (iobus_addr == BASE_ADDR + 32'd4);
  assign sel_stat = (iobus_addr == BASE_ADDR + 32'd8);

  assign blank = ctrl_q[4:1];
  assign dp    = ctrl_q[8:5];

  // Zero-latency read mux so the wrapper can OR it into its input mux.
  always_comb begin
    iobus_rd_data = 32'h0;
    iobus_hit     = 1'b0;
    unique case (1'b1)
      sel_data: begin
        iobus_rd_data = {16'h0, data_q};
        iobus_hit     = 1'b1;
      end
      sel_ctrl: begin
        iobus_rd_data = {22'h0, ctrl_q};
        iobus_hit     = 1'b1;
      end
      sel_stat: begin
        iobus_rd_data = {16'h0, frame, 6'h0, idx};
        iobus_hit     = 1'b1;
      end
      default: begin
        iobus_rd_data = 32'h0;
        iobus_hit     = 1'b0;
      end
    endcase
  end

  // Register writes; STATUS is read-only so only DATA and CTRL load.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      data_q <= 16'h0;
      ctrl_q <= 10'h1;
    end else if (iobus_wr) begin
      if (sel_data) data_q <= iobus_out[15:0];
      if (sel_ctrl) ctrl_q <= iobus_out[9:0];
    end
  end

  // Digit scan: free-running slot counter, digit index and frame count.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ref_cnt <= '0;
      idx     <= 2'd0;
      frame   <= 8'd0;
    end else if (ref_cnt == TC) begin
      ref_cnt <= '0;
      idx     <= idx + 2'd1;
      if (idx == 2'd3) frame <= frame + 8'd1;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Select the current nibble and decide whether the digit is dark.
  always_comb begin
    nib       = 4'h0;
    lead_zero = 1'b0;
    case (idx)
      2'd0: begin
        nib       = data_q[3:0];
        lead_zero = 1'b0;
      end
      2'd1: begin
        nib       = data_q[7:4];
        lead_zero = (data_q[15:4] == 12'h0);
      end
      2'd2: begin
        nib       = data_q[11:8];
        lead_zero = (data_q[15:8] == 8'h0);
      end
      default: begin
        nib       = data_q[15:12];
        lead_zero = (data_q[15:12] == 4'h0);
      end
    endcase
    dark = ~ctrl_q[0] | blank[idx] | (ctrl_q[9] & lead_zero);
  end

  // Active-low hex glyphs, bit order g..a.
  always_comb begin
    glyph = 7'h7F;
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end

  // Next pin values; a dark digit releases every anode and cathode.
  always_comb begin
    segs_next = 8'hFF;
    an_next   = 4'hF;
    if (!dark) begin
      segs_next = {~dp[idx], glyph};
      an_next   = ~(4'b0001 << idx);
    end
  end

  // Registered pins keep the IOBUS off any combinational pin path.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      segs <= 8'hFF;
      an   <= 4'hF;
    end else begin
      segs <= segs_next;
      an   <= an_next;
    end
  end

endmodule

// File: tb/tb_sseg_iobus_ctrl.sv
// Bench for sseg_iobus_ctrl with a fast refresh slot.
// Pins and STATUS are compared against a cycle-count reference model.
module tb_sseg_iobus_ctrl;

  localparam logic [31:0] BASE = 32'h1100C010;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = BASE;
  logic [31:0] wdata = 32'h0;
  logic        wr = 1'b0;
  logic [31:0] rd;
  logic        hit;
  logic [7:0]  segs;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sseg_iobus_ctrl #(
    .BASE_ADDR(BASE),
    .REFRESH_DIV(DIV)
  ) dut (
    .clk(clk),
    .RST(rst),
    .iobus_addr(addr),
    .iobus_out(wdata),
    .iobus_wr(wr),
    .iobus_rd_data(rd),
    .iobus_hit(hit),
    .segs(segs),
    .an(an)
  );

  // Reference model: clock edges since reset give digit and frame.
  int          cyc;
  logic [15:0] m_data;
  logic [9:0]  m_ctrl;
  logic [3:0]  exp_an;
  logic [7:0]  exp_segs;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      4'hA: return 7'h08;
      4'hB: return 7'h03;
      4'hC: return 7'h46;
      4'hD: return 7'h21;
      4'hE: return 7'h06;
      default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [11:0] pins(input int d, input logic [15:0] dv,
                                       input logic [9:0] cv);
    logic off;
    off = !cv[0] || cv[1+d] || (cv[9] && d > 0 && (dv >> (4*d)) == 16'd0);
    if (off) return 12'hFFF;
    return {~(4'b0001 << d), ~cv[5+d], glyph(4'((dv >> (4*d)) & 16'hF))};
  endfunction

  function automatic logic [31:0] m_status();
    return 32'(((cyc / (DIV*4)) % 256) * 256 + (cyc / DIV) % 4);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0;
      m_data <= 16'h0;
      m_ctrl <= 10'h1;
      {exp_an, exp_segs} <= 12'hFFF;
    end else begin
      {exp_an, exp_segs} <= pins((cyc / DIV) % 4, m_data, m_ctrl);
      if (wr && addr == BASE) m_data <= wdata[15:0];
      if (wr && addr == BASE + 32'd4) m_ctrl <= wdata[9:0];
      cyc <= cyc + 1;
    end
  end

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = a;
    wdata = v;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    addr = BASE;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] v,
                        output logic h);
    addr = a;
    #1;
    v = rd;
    h = hit;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic h;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      errors++;
      $display("FAIL reset_pins an=%b segs=%h want an=1111 segs=ff", an, segs);
    end
    rd_reg(BASE, v, h);
    checks++;
    if (v !== 32'h0 || h !== 1'b1) begin
      errors++;
      $display("FAIL reset_data got=%h hit=%b want=0 hit=1", v, h);
    end
    rd_reg(BASE + 4, v, h);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL reset_ctrl got=%h want=1", v);
    end
    rd_reg(BASE + 8, v, h);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_status got=%h want=0", v);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan();
    logic [31:0] v;
    logic h;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || segs !== 8'hC0) begin
        errors++;
        $display("FAIL scan_pins an=%b segs=%h want an=%b segs=c0",
                 an, segs, exp_an);
      end
      rd_reg(BASE + 8, v, h);
      checks++;
      if (v !== m_status()) begin
        errors++;
        $display("FAIL scan_status got=%h want=%h", v, m_status());
      end
    end
    checks++;
    if (v[15:8] !== 8'd1) begin
      errors++;
      $display("FAIL scan_frame1 got=%0d want=1", v[15:8]);
    end
  endtask

  task automatic test_values();
    logic [31:0] v;
    logic h;
    logic [7:0] want [4];
    want = '{8'h0E, 8'hB0, 8'h88, 8'hF9};
    wr_reg(BASE, 32'hFFFF1A3F);
    wr_reg(BASE + 4, 32'h21);
    rd_reg(BASE, v, h);
    checks++;
    if (v !== 32'h00001A3F || h !== 1'b1) begin
      errors++;
      $display("FAIL values_read got=%h hit=%b want=00001a3f hit=1", v, h);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || segs !== exp_segs) begin
        errors++;
        $display("FAIL values_pins an=%b segs=%h want an=%b segs=%h",
                 an, segs, exp_an, exp_segs);
      end
      for (int d = 0; d < 4; d++) begin
        if (an == ~(4'b0001 << d)) begin
          checks++;
          if (segs !== want[d]) begin
            errors++;
            $display("FAIL values_glyph digit=%0d segs=%h want=%h",
                     d, segs, want[d]);
          end
        end
      end
    end
  endtask

  task automatic test_lzs();
    int lit;
    int drk;
    wr_reg(BASE + 4, 32'h201);
    wr_reg(BASE, 32'h0005);
    @(negedge clk);
    lit = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || segs !== exp_segs) begin
        errors++;
        $display("FAIL lzs5_pins an=%b segs=%h want an=%b segs=%h",
                 an, segs, exp_an, exp_segs);
      end
      if (an != 4'hF) begin
        lit++;
        checks++;
        if (an !== 4'b1110 || segs !== 8'h92) begin
          errors++;
          $display("FAIL lzs5_lit an=%b segs=%h want an=1110 segs=92",
                   an, segs);
        end
      end
    end
    checks++;
    if (lit !== 4) begin
      errors++;
      $display("FAIL lzs5_count lit=%0d want=4", lit);
    end
    wr_reg(BASE, 32'h0500);
    @(negedge clk);
    drk = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || segs !== exp_segs) begin
        errors++;
        $display("FAIL lzs500_pins an=%b segs=%h want an=%b segs=%h",
                 an, segs, exp_an, exp_segs);
      end
      if (an == 4'hF) drk++;
    end
    checks++;
    if (drk !== 4) begin
      errors++;
      $display("FAIL lzs500_count dark=%0d want=4", drk);
    end
  endtask

  task automatic test_blank();
    int drk;
    logic [31:0] v;
    logic [31:0] v2;
    logic h;
    wr_reg(BASE + 4, 32'h13);
    @(negedge clk);
    drk = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an || segs !== exp_segs) begin
        errors++;
        $display("FAIL blank_pins an=%b segs=%h want an=%b segs=%h",
                 an, segs, exp_an, exp_segs);
      end
      if (an == 4'hF) drk++;
      else if (an != 4'b1101 && an != 4'b1011) begin
        errors++;
        $display("FAIL blank_digit an=%b want 1101 or 1011", an);
      end
    end
    checks++;
    if (drk !== 8) begin
      errors++;
      $display("FAIL blank_count dark=%0d want=8", drk);
    end
    wr_reg(BASE + 4, 32'h0);
    @(negedge clk);
    rd_reg(BASE + 8, v, h);
    checks++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      errors++;
      $display("FAIL disable_pins an=%b segs=%h want an=1111 segs=ff",
               an, segs);
    end
    repeat (4) @(negedge clk);
    rd_reg(BASE + 8, v2, h);
    checks++;
    if (v2[1:0] !== 2'(v[1:0] + 2'd1) || v2 !== m_status()) begin
      errors++;
      $display("FAIL disable_idx got=%h want=%h", v2, m_status());
    end
    checks++;
    if (an !== 4'hF) begin
      errors++;
      $display("FAIL disable_hold an=%b want=1111", an);
    end
  endtask

  task automatic test_decode();
    logic [31:0] v;
    logic h;
    logic [31:0] miss [4];
    miss = '{BASE + 1, BASE + 12, BASE + 3, 32'h0};
    wr_reg(BASE + 8, 32'hFFFFFFFF);
    wr_reg(BASE + 1, 32'hFFFFFFFF);
    wr_reg(BASE + 12, 32'hFFFFFFFF);
    wr_reg(BASE + 5, 32'hFFFFFFFF);
    rd_reg(BASE, v, h);
    checks++;
    if (v !== 32'h0500 || v !== {16'h0, m_data}) begin
      errors++;
      $display("FAIL decode_data got=%h want=00000500", v);
    end
    rd_reg(BASE + 4, v, h);
    checks++;
    if (v !== 32'h0 || v !== {22'h0, m_ctrl}) begin
      errors++;
      $display("FAIL decode_ctrl got=%h want=0", v);
    end
    for (int i = 0; i < 4; i++) begin
      rd_reg(miss[i], v, h);
      checks++;
      if (v !== 32'h0 || h !== 1'b0) begin
        errors++;
        $display("FAIL decode_miss addr=%h got=%h hit=%b want=0 hit=0",
                 miss[i], v, h);
      end
    end
    rd_reg(BASE + 8, v, h);
    checks++;
    if (h !== 1'b1 || v !== m_status()) begin
      errors++;
      $display("FAIL decode_status got=%h hit=%b want=%h", v, h, m_status());
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic h;
    int n;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 0) wr_reg(BASE, $urandom());
      else wr_reg(BASE + 4, $urandom());
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        @(negedge clk);
        checks++;
        if (an !== exp_an || segs !== exp_segs) begin
          errors++;
          $display("FAIL random_pins an=%b segs=%h want an=%b segs=%h",
                   an, segs, exp_an, exp_segs);
        end
      end
      rd_reg(BASE + 4, v, h);
      checks++;
      if (v !== {22'h0, m_ctrl}) begin
        errors++;
        $display("FAIL random_ctrl got=%h want=%h", v, {22'h0, m_ctrl});
      end
      rd_reg(BASE, v, h);
      checks++;
      if (v !== {16'h0, m_data}) begin
        errors++;
        $display("FAIL random_data got=%h want=%h", v, {16'h0, m_data});
      end
    end
  endtask

  task automatic test_frame_wrap();
    logic [31:0] v;
    logic h;
    logic [7:0] prev;
    bit seen;
    int after;
    wr_reg(BASE, 32'h8421);
    wr_reg(BASE + 4, 32'h1);
    seen = 0;
    after = 0;
    rd_reg(BASE + 8, v, h);
    prev = v[15:8];
    for (int i = 0; i < 4300 && after < 20; i++) begin
      @(negedge clk);
      rd_reg(BASE + 8, v, h);
      checks++;
      if (v !== m_status() || an !== exp_an || segs !== exp_segs) begin
        errors++;
        $display("FAIL frame_run status=%h an=%b segs=%h want %h %b %h",
                 v, an, segs, m_status(), exp_an, exp_segs);
      end
      if (prev == 8'd255 && v[15:8] == 8'd0) seen = 1;
      if (seen) after++;
      prev = v[15:8];
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL frame_wrap seen=%0d want=1", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic h;
    bit found;
    wr_reg(BASE, 32'hBEEF);
    wr_reg(BASE + 4, 32'h3E1);
    found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      rd_reg(BASE + 8, v, h);
      if (v[1:0] == 2'd2) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_wait idx never reached 2");
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (an !== 4'hF || segs !== 8'hFF) begin
      errors++;
      $display("FAIL midreset_pins an=%b segs=%h want an=1111 segs=ff",
               an, segs);
    end
    rd_reg(BASE, v, h);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL midreset_data got=%h want=0", v);
    end
    rd_reg(BASE + 4, v, h);
    checks++;
    if (v !== 32'h1) begin
      errors++;
      $display("FAIL midreset_ctrl got=%h want=1", v);
    end
    rd_reg(BASE + 8, v, h);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL midreset_status got=%h want=0", v);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rd_reg(BASE + 8, v, h);
      checks++;
      if (v[1:0] !== 2'((i + 1) / DIV) || an !== exp_an || segs !== exp_segs) begin
        errors++;
        $display("FAIL restart idx=%0d an=%b segs=%h want idx=%0d an=%b segs=%h",
                 v[1:0], an, segs, (i + 1) / DIV, exp_an, exp_segs);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_values();
    test_lzs();
    test_blank();
    test_decode();
    test_random();
    test_frame_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
